// File: rtl/bt_pipe_flow_ctrl.sv
// rtl/bt_pipe_flow_ctrl.sv - block-granular flow control, soft-clear sequencing and status for the BTPipe loopback FIFO
module bt_pipe_flow_ctrl #(
    parameter int DEPTH         = 1024,
    parameter int BLOCK_WORDS   = 256,
    parameter int CLR_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 16,
    parameter int CW            = $clog2(DEPTH + 1)
) (
    input  logic          okClk,
    input  logic          rst_n,
    input  logic          soft_clr,
    input  logic          inv_req,
    input  logic          fifo_wr_en,
    input  logic          fifo_rd_en,
    input  logic          in_blockstrobe,
    input  logic          out_blockstrobe,
    output logic          fifo_srst,
    output logic          pipe_in_ready,
    output logic          pipe_out_ready,
    output logic          inv_sel,
    output logic [CW-1:0] fill_level,
    output logic [15:0]   in_blocks,
    output logic [15:0]   out_blocks,
    output logic          ovf_err,
    output logic          unf_err,
    output logic          busy
);

    localparam int PMAX = (CLR_CYCLES > SETTLE_CYCLES) ? CLR_CYCLES : SETTLE_CYCLES;
    localparam int PW   = $clog2(PMAX + 1);
    localparam int WW   = $clog2(BLOCK_WORDS);

    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [CW-1:0] BLK_LVL  = CW'(BLOCK_WORDS);
    localparam logic [CW-1:0] LVL_ONE  = CW'(1);
    localparam logic [WW-1:0] W_ONE    = WW'(1);
    localparam logic [WW-1:0] W_LAST   = WW'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [PW-1:0]   phase, phase_next;
    logic            soft_clr_q;
    logic            clr_go;
    logic            run;

    logic            wr_ok, rd_ok;
    logic [CW-1:0]   level_next;
    logic [WW-1:0]   in_wcnt, out_wcnt;
    logic            in_active, out_active;
    logic            in_active_next, out_active_next;
    logic            in_last, out_last;
    logic            in_stb, out_stb;
    logic            in_eval, out_eval;
    logic            in_ready_next, out_ready_next;

    assign clr_go = soft_clr & ~soft_clr_q;
    assign run    = (state == ST_RUN);

    // State and phase counter registers
    always_ff @(posedge okClk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_CLEAR;
            phase      <= '0;
            soft_clr_q <= 1'b0;
        end else begin
            state      <= state_next;
            phase      <= phase_next;
            soft_clr_q <= soft_clr;
        end
    end

    // Next state: a soft_clr rising edge restarts the clear from any state
    always_comb begin
        state_next = state;
        phase_next = phase;
        if (clr_go) begin
            state_next = ST_CLEAR;
            phase_next = '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (phase == PW'(CLR_CYCLES - 1)) begin
                        state_next = ST_SETTLE;
                        phase_next = '0;
                    end else begin
                        phase_next = phase + PW'(1);
                    end
                end
                ST_SETTLE: begin
                    if (phase == PW'(SETTLE_CYCLES - 1)) begin
                        state_next = ST_RUN;
                        phase_next = '0;
                    end else begin
                        phase_next = phase + PW'(1);
                    end
                end
                ST_RUN: begin
                    phase_next = '0;
                end
                default: begin
                    state_next = ST_CLEAR;
                    phase_next = '0;
                end
            endcase
        end
    end

    // Occupancy, block tracking and block-granular ready evaluation
    always_comb begin
        // a simultaneous pair is always legal, even at empty or full
        wr_ok = run & fifo_wr_en & (fifo_rd_en | (fill_level != FULL_LVL));
        rd_ok = run & fifo_rd_en & (fifo_wr_en | (fill_level != '0));

        level_next = fill_level;
        if (wr_ok & ~rd_ok)
            level_next = fill_level + LVL_ONE;
        else if (rd_ok & ~wr_ok)
            level_next = fill_level - LVL_ONE;

        in_last  = wr_ok & (in_wcnt == W_LAST);
        out_last = rd_ok & (out_wcnt == W_LAST);
        in_stb   = run & in_blockstrobe;
        out_stb  = run & out_blockstrobe;

        in_active_next  = in_last  ? in_stb  : (in_active  | in_stb);
        out_active_next = out_last ? out_stb : (out_active | out_stb);

        // ready is frozen from the block strobe until the block's last word
        in_eval  = in_last  | (~in_active  & ~in_stb);
        out_eval = out_last | (~out_active & ~out_stb);

        in_ready_next  = pipe_in_ready;
        out_ready_next = pipe_out_ready;
        if (state_next != ST_RUN) begin
            in_ready_next  = 1'b0;
            out_ready_next = 1'b0;
        end else begin
            if (in_eval)
                in_ready_next = ((FULL_LVL - level_next) >= BLK_LVL);
            if (out_eval)
                out_ready_next = (level_next >= BLK_LVL);
        end
    end

    // Datapath registers; a clear wipes counts, errors and in-flight blocks
    always_ff @(posedge okClk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_srst      <= 1'b1;
            busy           <= 1'b1;
            pipe_in_ready  <= 1'b0;
            pipe_out_ready <= 1'b0;
            fill_level     <= '0;
            in_wcnt        <= '0;
            out_wcnt       <= '0;
            in_active      <= 1'b0;
            out_active     <= 1'b0;
            in_blocks      <= '0;
            out_blocks     <= '0;
            ovf_err        <= 1'b0;
            unf_err        <= 1'b0;
        end else begin
            fifo_srst      <= (state_next == ST_CLEAR);
            busy           <= (state_next != ST_RUN);
            pipe_in_ready  <= in_ready_next;
            pipe_out_ready <= out_ready_next;
            if (clr_go) begin
                fill_level <= '0;
                in_wcnt    <= '0;
                out_wcnt   <= '0;
                in_active  <= 1'b0;
                out_active <= 1'b0;
                in_blocks  <= '0;
                out_blocks <= '0;
                ovf_err    <= 1'b0;
                unf_err    <= 1'b0;
            end else begin
                fill_level <= level_next;
                in_active  <= in_active_next;
                out_active <= out_active_next;
                if (wr_ok)
                    in_wcnt <= in_last ? '0 : in_wcnt + W_ONE;
                if (rd_ok)
                    out_wcnt <= out_last ? '0 : out_wcnt + W_ONE;
                if (in_last)
                    in_blocks <= in_blocks + 16'd1;
                if (out_last)
                    out_blocks <= out_blocks + 16'd1;
                if (run & fifo_wr_en & ~fifo_rd_en & (fill_level == FULL_LVL))
                    ovf_err <= 1'b1;
                if (run & fifo_rd_en & ~fifo_wr_en & (fill_level == '0))
                    unf_err <= 1'b1;
            end
        end
    end

    // Invert select only changes between output blocks
    always_ff @(posedge okClk or negedge rst_n) begin
        if (!rst_n)
            inv_sel <= 1'b0;
        else if (~out_active & ~out_blockstrobe)
            inv_sel <= inv_req;
    end

endmodule

// File: tb/tb_bt_pipe_flow_ctrl.sv
// tb/tb_bt_pipe_flow_ctrl.sv - randomized host traffic against a word-count reference model
module tb_bt_pipe_flow_ctrl;

    localparam int DEPTH  = 1024;
    localparam int BW     = 256;
    localparam int CLR    = 4;
    localparam int SETTLE = 16;
    localparam int CW     = $clog2(DEPTH + 1);
    localparam int EPOCH_LEN = 1200;

    logic          okClk = 1'b0;
    logic          rst_n;
    logic          soft_clr, inv_req, fifo_wr_en, fifo_rd_en;
    logic          in_blockstrobe, out_blockstrobe;
    logic          fifo_srst, pipe_in_ready, pipe_out_ready, inv_sel;
    logic [CW-1:0] fill_level;
    logic [15:0]   in_blocks, out_blocks;
    logic          ovf_err, unf_err, busy;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state: time since clear, level, total counted words
    int          m_t;
    int          m_lvl;
    int unsigned m_in_tot, m_out_tot;
    bit          m_in_blk, m_out_blk, m_in_rdy, m_out_rdy;
    bit          m_inv, m_ovf, m_unf, m_sclr_q;

    bt_pipe_flow_ctrl #(
        .DEPTH(DEPTH), .BLOCK_WORDS(BW), .CLR_CYCLES(CLR), .SETTLE_CYCLES(SETTLE)
    ) dut (
        .okClk(okClk), .rst_n(rst_n), .soft_clr(soft_clr), .inv_req(inv_req),
        .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en),
        .in_blockstrobe(in_blockstrobe), .out_blockstrobe(out_blockstrobe),
        .fifo_srst(fifo_srst), .pipe_in_ready(pipe_in_ready), .pipe_out_ready(pipe_out_ready),
        .inv_sel(inv_sel), .fill_level(fill_level), .in_blocks(in_blocks), .out_blocks(out_blocks),
        .ovf_err(ovf_err), .unf_err(unf_err), .busy(busy)
    );

    always #5 okClk = ~okClk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0d expected=%0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_update();
        bit run, rise, wr_c, rd_c, in_last, out_last, old_blk;
        if (!rst_n) begin
            m_t = 0; m_lvl = 0; m_in_tot = 0; m_out_tot = 0;
            m_in_blk = 0; m_out_blk = 0; m_in_rdy = 0; m_out_rdy = 0;
            m_inv = 0; m_ovf = 0; m_unf = 0; m_sclr_q = 0;
            return;
        end
        if (!m_out_blk && !out_blockstrobe)
            m_inv = inv_req;
        rise = soft_clr && !m_sclr_q;
        m_sclr_q = soft_clr;
        run = (m_t >= CLR + SETTLE);
        if (rise) begin
            m_t = 0; m_lvl = 0; m_in_tot = 0; m_out_tot = 0;
            m_in_blk = 0; m_out_blk = 0; m_in_rdy = 0; m_out_rdy = 0;
            m_ovf = 0; m_unf = 0;
            return;
        end
        if (!run) begin
            m_t++;
            if (m_t == CLR + SETTLE) begin
                m_in_rdy  = (DEPTH - m_lvl >= BW);
                m_out_rdy = (m_lvl >= BW);
            end
            return;
        end
        wr_c = fifo_wr_en && (fifo_rd_en || m_lvl < DEPTH);
        rd_c = fifo_rd_en && (fifo_wr_en || m_lvl > 0);
        if (fifo_wr_en && !fifo_rd_en && m_lvl == DEPTH) m_ovf = 1;
        if (fifo_rd_en && !fifo_wr_en && m_lvl == 0)     m_unf = 1;
        m_lvl = m_lvl + int'(wr_c) - int'(rd_c);
        if (wr_c) m_in_tot++;
        if (rd_c) m_out_tot++;
        in_last  = wr_c && (m_in_tot % BW == 0);
        out_last = rd_c && (m_out_tot % BW == 0);

        old_blk  = m_in_blk;
        m_in_blk = in_last ? in_blockstrobe : (m_in_blk || in_blockstrobe);
        if (in_last || (!old_blk && !in_blockstrobe))
            m_in_rdy = (DEPTH - m_lvl >= BW);

        old_blk   = m_out_blk;
        m_out_blk = out_last ? out_blockstrobe : (m_out_blk || out_blockstrobe);
        if (out_last || (!old_blk && !out_blockstrobe))
            m_out_rdy = (m_lvl >= BW);
    endtask

    task automatic check_all();
        check("fifo_srst",      fifo_srst,      (m_t < CLR) ? 1 : 0);
        check("busy",           busy,           (m_t < CLR + SETTLE) ? 1 : 0);
        check("pipe_in_ready",  pipe_in_ready,  m_in_rdy);
        check("pipe_out_ready", pipe_out_ready, m_out_rdy);
        check("inv_sel",        inv_sel,        m_inv);
        check("fill_level",     fill_level,     m_lvl);
        check("in_blocks",      in_blocks,      (m_in_tot / BW) & 32'hFFFF);
        check("out_blocks",     out_blocks,     (m_out_tot / BW) & 32'hFFFF);
        check("ovf_err",        ovf_err,        m_ovf);
        check("unf_err",        unf_err,        m_unf);
    endtask

    task automatic step();
        @(posedge okClk);
        model_update();
        @(negedge okClk);
        check_all();
    endtask

    // per-epoch traffic profile: write %, read %, rogue (ignores ready), clear before
    int ep_wr    [8] = '{90, 80,  0, 40, 90, 95, 50, 50};
    int ep_rd    [8] = '{ 0, 80, 90, 60,  0, 30, 50, 50};
    bit ep_rogue [8] = '{ 0,  0,  0,  1,  0,  1,  0,  1};
    bit ep_clear [8] = '{ 0,  0,  0,  1,  0,  0,  1,  0};

    initial begin
        int in_left, out_left, sclr_cnt;
        rst_n = 1'b0;
        soft_clr = 0; inv_req = 0; fifo_wr_en = 0; fifo_rd_en = 0;
        in_blockstrobe = 0; out_blockstrobe = 0;
        in_left = 0; out_left = 0; sclr_cnt = 0;

        for (int i = 0; i < 3; i++) step();
        rst_n = 1'b1;
        for (int i = 0; i < CLR + SETTLE + 2; i++) step();

        for (int e = 0; e < 8; e++) begin
            if (ep_clear[e]) begin
                soft_clr = 1'b1; step(); step();
                soft_clr = 1'b0;
                for (int i = 0; i < CLR + SETTLE + 1; i++) step();
            end
            in_left = 0; out_left = 0;
            for (int c = 0; c < EPOCH_LEN; c++) begin
                fifo_wr_en = 0; fifo_rd_en = 0;
                in_blockstrobe = 0; out_blockstrobe = 0;
                if (ep_rogue[e]) begin
                    fifo_wr_en      = ($urandom_range(0, 99) < ep_wr[e]);
                    fifo_rd_en      = ($urandom_range(0, 99) < ep_rd[e]);
                    in_blockstrobe  = ($urandom_range(0, 99) < 3);
                    out_blockstrobe = ($urandom_range(0, 99) < 3);
                end else begin
                    if (in_left == 0) begin
                        if (pipe_in_ready && $urandom_range(0, 99) < 30) begin
                            in_blockstrobe = 1; in_left = BW;
                        end
                    end else if ($urandom_range(0, 99) < ep_wr[e]) begin
                        fifo_wr_en = 1; in_left--;
                    end
                    if (out_left == 0) begin
                        if (pipe_out_ready && $urandom_range(0, 99) < 30) begin
                            out_blockstrobe = 1; out_left = BW;
                        end
                    end else if ($urandom_range(0, 99) < ep_rd[e]) begin
                        fifo_rd_en = 1; out_left--;
                    end
                end
                if ($urandom_range(0, 99) < 5) inv_req = ~inv_req;
                if (sclr_cnt > 0) begin
                    sclr_cnt--;
                    soft_clr = (sclr_cnt > 0);
                end else if ($urandom_range(0, 999) == 0) begin
                    soft_clr = 1; sclr_cnt = 3;
                end
                step();
            end
        end
        fifo_wr_en = 0; fifo_rd_en = 0; in_blockstrobe = 0; out_blockstrobe = 0; soft_clr = 0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bt_pipe_flow_ctrl.md
Name: bt_pipe_flow_ctrl

Overview:
- Flow controller sitting between the okBTPipeIn/okBTPipeOut endpoints and the shared loopback FIFO.
- Tracks FIFO occupancy and gates each pipe's ep_ready at block granularity, so a host block transfer never stalls mid-block.
- Sequences FIFO soft-clear (srst pulse plus settle window).
- Latches the output-invert select only on block boundaries; keeps per-direction block counters and sticky error flags for wire-out status.

Parameters:
- DEPTH, 1024, FIFO depth in words.
- BLOCK_WORDS, 256, words per BTPipe block; must divide DEPTH, must be at least 2.
- CLR_CYCLES, 4, cycles fifo_srst is held high.
- SETTLE_CYCLES, 16, cycles after srst before pipes are enabled.
- CW, clog2(DEPTH+1), derived width of fill_level.

Ports:
- okClk  in  1  interface clock; everything is synchronous to it.
- rst_n  in  1  asynchronous active-low reset.
- soft_clr  in  1  level from wire-in; a rising edge starts a clear.
- inv_req  in  1  requested invert select from wire-in.
- fifo_wr_en  in  1  ep_write from the pipe-in endpoint.
- fifo_rd_en  in  1  ep_read from the pipe-out endpoint.
- in_blockstrobe  in  1  pipe-in block start.
- out_blockstrobe  in  1  pipe-out block start.
- fifo_srst  out  1  FIFO synchronous reset.
- pipe_in_ready  out  1  ep_ready to pipe-in.
- pipe_out_ready  out  1  ep_ready to pipe-out.
- inv_sel  out  1  invert select applied to FIFO dout.
- fill_level  out  CW  words currently in the FIFO.
- in_blocks  out  16  completed input blocks; wraps.
- out_blocks  out  16  completed output blocks; wraps.
- ovf_err  out  1  sticky: write while full.
- unf_err  out  1  sticky: read while empty.
- busy  out  1  high whenever state is not RUN.

Behaviour:
- Reset values (rst_n low): state=CLEAR, phase counter=0, fifo_srst=1, both readies=0, inv_sel=0, fill_level=0, all counters=0, errors=0, busy=1.
- FSM states: CLEAR, SETTLE, RUN.
  - CLEAR: fifo_srst=1 for exactly CLR_CYCLES cycles, then go to SETTLE.
  - SETTLE: fifo_srst=0, readies=0, for SETTLE_CYCLES cycles, then go to RUN.
  - RUN: stays until a clear is requested.
- Clear request:
  - soft_clr is registered; its rising edge, detected against the registered copy, moves any state to CLEAR on the next cycle.
  - The clear zeroes fill_level, word/block counters and errors. inv_sel is kept.
  - A clear arriving mid-block aborts the block silently.
- Outside RUN, fifo_wr_en and fifo_rd_en are ignored: no count change, no error.
- Occupancy in RUN:
  - wr only: +1.
  - rd only: −1.
  - wr and rd together: unchanged.
  - wr at level==DEPTH: set ovf_err, write not counted.
  - rd at level==0: set unf_err, read not counted.
  - Simultaneous wr and rd at level 0 or level DEPTH count as a legal pair (no error, no change).
- Word counters in_wcnt/out_wcnt (0..BLOCK_WORDS−1):
  - Each increments on its counted strobe and wraps at BLOCK_WORDS.
  - The wrap cycle increments in_blocks/out_blocks.
  - Block strobes are used only to flag a block as active; an active block with wcnt==0 is treated as in progress.
- Ready generation (registered, RUN only):
  - When no input block is active, pipe_in_ready(next) = (DEPTH − level_next ≥ BLOCK_WORDS).
  - When no output block is active, pipe_out_ready(next) = (level_next ≥ BLOCK_WORDS).
  - While a block is active, its ready is held at the value latched at the block start.
  - On the last-word cycle of a block, ready is re-evaluated from level_next. This allows back-to-back blocks.
- inv_sel loads inv_req on any cycle where no output block is active and out_blockstrobe is low. Changes requested mid-block apply after the block completes.
- Latencies:
  - fill_level is updated one cycle after the strobe.
  - busy = (state != RUN), registered.
  - The first pipe_in_ready after a clear is asserted on the first RUN cycle.

Test Plan:
- Release rst_n → fifo_srst high for 4 cycles, then 16 SETTLE cycles; busy=1 throughout. First RUN cycle: pipe_in_ready=1, pipe_out_ready=0, busy=0.
- One 256-word input block → fill_level=256, in_blocks=1, pipe_out_ready=1. Three more blocks → level 1024, pipe_in_ready=0, in_blocks=4.
- At level 768 with an input block started, the host keeps writing to 1024 → pipe_in_ready stays 1 until the last word, then drops. Then read one 256-word block → pipe_in_ready returns 1, out_blocks=1.
- Simultaneous wr and rd for 100 cycles at level 300 → level stays 300, no errors. Force wr at 1024 → ovf_err=1, level 1024. Force rd at 0 after a clear → unf_err=1.
- Toggle inv_req at word 10 of an output block → inv_sel unchanged until the cycle after word 256.
- soft_clr rising edge at word 100 of an input block → CLEAR next cycle: readies 0, fill_level, counters and errors zeroed; RUN resumes after 20 cycles.
